// File: rtl/rom_download_sequencer.sv
// rom_download_sequencer
// Streams a ROM image from a byte-wide valid/ready source into the DLROM
// write ports (ROMAD/ROMDT/ROMEN).  Each accepted byte produces one
// single-cycle ROMEN pulse, followed by GAP_CYCLES idle cycles.  The download
// ends after the byte at LAST_ADRS is written.  Bytes offered after
// completion are dropped and flagged on DL_ERR.
//
// Optional feature: define ROMDL_CHKSUM_EN to add the CHKSUM output, a
// modulo-256 sum of every byte written with ROMEN.
module rom_download_sequencer #(
  parameter logic [17:0] LAST_ADRS  = 18'h208FF,
  parameter int unsigned GAP_CYCLES = 1
) (
  input  logic        ROMCL,
  input  logic        RESET_N,
  input  logic        DL_START,
  input  logic        DL_VALID,
  input  logic [7:0]  DL_DATA,
  output logic        DL_READY,
  output logic [17:0] ROMAD,
  output logic [7:0]  ROMDT,
  output logic        ROMEN,
  output logic        DL_BUSY,
  output logic        DL_DONE,
  output logic        DL_ERR
`ifdef ROMDL_CHKSUM_EN
  ,
  output logic [7:0]  CHKSUM
`endif
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACCEPT = 3'd1,
    WRITE  = 3'd2,
    GAP    = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Value loaded into the gap down-counter; it expires when it reaches zero,
  // so a load of GAP_CYCLES-1 yields exactly GAP_CYCLES idle cycles.
  localparam logic [3:0] GAP_LOAD = (GAP_CYCLES > 0) ? 4'(GAP_CYCLES - 1) : 4'd0;
  localparam bit         HAS_GAP  = (GAP_CYCLES > 0);

  state_t      state_reg;
  logic [17:0] addr_cnt_reg;
  logic [3:0]  gap_cnt_reg;

  // Download sequencer: state, address counter and all registered outputs.
  always_ff @(posedge ROMCL or negedge RESET_N) begin
    if (!RESET_N) begin
      state_reg    <= IDLE;
      addr_cnt_reg <= '0;
      gap_cnt_reg  <= '0;
      ROMAD        <= '0;
      ROMDT        <= '0;
      ROMEN        <= 1'b0;
      DL_READY     <= 1'b0;
      DL_BUSY      <= 1'b0;
      DL_DONE      <= 1'b0;
      DL_ERR       <= 1'b0;
`ifdef ROMDL_CHKSUM_EN
      CHKSUM       <= '0;
`endif
    end else begin
      // ROMEN is a one-cycle strobe; a pulse in flight always ends here,
      // even when a restart arrives on the same edge.
      ROMEN <= 1'b0;
      if (DL_START) begin
        // Restart wins over everything, including a coincident handshake
        // whose byte is therefore discarded.
        state_reg    <= ACCEPT;
        addr_cnt_reg <= '0;
        gap_cnt_reg  <= '0;
        DL_READY     <= 1'b1;
        DL_BUSY      <= 1'b1;
        DL_DONE      <= 1'b0;
        DL_ERR       <= 1'b0;
`ifdef ROMDL_CHKSUM_EN
        CHKSUM       <= '0;
`endif
      end else begin
        case (state_reg)
          IDLE: begin
            state_reg <= IDLE;
          end
          ACCEPT: begin
            if (DL_VALID) begin
              ROMAD     <= addr_cnt_reg;
              ROMDT     <= DL_DATA;
              ROMEN     <= 1'b1;
              DL_READY  <= 1'b0;
              state_reg <= WRITE;
`ifdef ROMDL_CHKSUM_EN
              CHKSUM    <= CHKSUM + DL_DATA;
`endif
            end
          end
          WRITE: begin
            // Saturate at the last address so the counter never wraps.
            if (addr_cnt_reg != LAST_ADRS) begin
              addr_cnt_reg <= addr_cnt_reg + 18'd1;
            end
            if (ROMAD == LAST_ADRS) begin
              state_reg <= DONE;
              DL_DONE   <= 1'b1;
              DL_BUSY   <= 1'b0;
            end else if (HAS_GAP) begin
              state_reg   <= GAP;
              gap_cnt_reg <= GAP_LOAD;
            end else begin
              state_reg <= ACCEPT;
              DL_READY  <= 1'b1;
            end
          end
          GAP: begin
            if (gap_cnt_reg == 4'd0) begin
              state_reg <= ACCEPT;
              DL_READY  <= 1'b1;
            end else begin
              gap_cnt_reg <= gap_cnt_reg - 4'd1;
            end
          end
          DONE: begin
            if (DL_VALID) begin
              DL_ERR <= 1'b1;
            end
          end
          default: begin
            state_reg <= IDLE;
            DL_READY  <= 1'b0;
            DL_BUSY   <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
